piggy_bank_reporter: RTL

//  Parametrised coin-bank core: N_CH coin channels, each with its own count and denomination.

---
 rtl/piggy_pkg.sv | 19 +
 rtl/uart_tx_byte.sv | 58 +++++
 rtl/piggy_bank_reporter.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/piggy_pkg.sv
// Shared constants, FSM encoding and frame helpers for the piggy bank reporter.
package piggy_pkg;

  localparam logic [7:0] FRAME_HDR = 8'hA5;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    SEND = 3'd2,
    GAP  = 3'd3,
    DONE = 3'd4
  } state_t;

  // Report frame length: header, one byte per channel, two total bytes, checksum.
  function automatic int unsigned frame_len(input int unsigned n);
    return n + 4;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// UART 8N1 byte transmitter, LSB first; line idles high.
module uart_tx_byte
  import piggy_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 87
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] data,
  output logic       busy,
  output logic       byte_done,
  output logic       serial
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] clk_cnt;
  logic [3:0]       bit_idx;
  logic [7:0]       shreg;

  // Bit timing: bit 0 is the start bit, 1..8 data, 9 stop; ones shift in behind the data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy      <= 1'b0;
      byte_done <= 1'b0;
      serial    <= 1'b1;
      clk_cnt   <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
    end else begin
      byte_done <= 1'b0;
      if (!busy) begin
        if (start) begin
          busy    <= 1'b1;
          serial  <= 1'b0;
          clk_cnt <= '0;
          bit_idx <= '0;
          shreg   <= data;
        end
      end else if (clk_cnt == CNT_LAST) begin
        clk_cnt <= '0;
        if (bit_idx == 4'd9) begin
          busy      <= 1'b0;
          byte_done <= 1'b1;
        end else begin
          serial  <= shreg[0];
          shreg   <= {1'b1, shreg[7:1]};
          bit_idx <= bit_idx + 4'd1;
        end
      end else begin
        clk_cnt <= clk_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/piggy_bank_reporter.sv
// Coin bank: per-channel counters, saturating weighted total and framed UART report.
module piggy_bank_reporter
  import piggy_pkg::*;
#(
  parameter int unsigned       N_CH         = 4,
  parameter int unsigned       CNT_W        = 8,
  parameter int unsigned       TOT_W        = 16,
  // Channel i denomination is DENOMS[8*i+:8]; default ch0..ch3 = 1, 2, 5, 10.
  parameter logic [N_CH*8-1:0] DENOMS       = {8'd10, 8'd5, 8'd2, 8'd1},
  parameter int unsigned       CLKS_PER_BIT = 87
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_CH-1:0]  coin_in,
  input  logic             clear,
  input  logic             report_req,
  output logic             tx_serial,
  output logic             tx_active,
  output logic             tx_done,
  output logic [TOT_W-1:0] total,
  output logic [N_CH-1:0]  sat,
  output logic             overflow
);

  localparam int unsigned FLEN  = frame_len(N_CH);
  localparam int unsigned IDX_W = 4;
  localparam int unsigned BUF_N = 16;
  localparam int unsigned SUM_W = TOT_W + 4;
  localparam logic [TOT_W-1:0] TOT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [N_CH-1:0]  coin_prev;
  logic [N_CH-1:0]  coin_edge_c;
  logic [N_CH-1:0]  counted_c;
  logic             req_prev;
  logic             req_edge_c;
  logic             trig_c;
  logic [SUM_W-1:0] sum_c;
  logic [CNT_W-1:0] cnt [N_CH];
  logic             pending;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic [7:0]       frame_c   [BUF_N];
  logic [7:0]       frame_buf [BUF_N];
  logic [15:0]      tot16_c;
  logic [7:0]       csum_c;
  logic             uart_start_c;
  logic [7:0]       uart_data_c;
  logic             uart_busy;
  logic             uart_byte_done;
  logic             tx_active_nxt;

  // Edge detection, saturation gating and the widened total sum.
  always_comb begin
    coin_edge_c = coin_in & ~coin_prev;
    req_edge_c  = report_req & ~req_prev;
    counted_c   = '0;
    sum_c       = SUM_W'(total);
    for (int i = 0; i < N_CH; i++) begin
      if (coin_edge_c[i] && (cnt[i] != CNT_MAX)) begin
        counted_c[i] = 1'b1;
        sum_c        = sum_c + SUM_W'(DENOMS[8*i +: 8]);
      end
    end
    trig_c = clear | req_edge_c | (|counted_c);
  end

  // Live bank state: counters, total, sticky flags and the report-pending flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      coin_prev <= '0;
      req_prev  <= 1'b0;
      for (int i = 0; i < N_CH; i++) cnt[i] <= '0;
      total     <= '0;
      sat       <= '0;
      overflow  <= 1'b0;
      pending   <= 1'b0;
    end else begin
      coin_prev <= coin_in;
      req_prev  <= report_req;
      pending   <= trig_c | (pending & (state != IDLE));
      if (clear) begin
        for (int i = 0; i < N_CH; i++) cnt[i] <= '0;
        total    <= '0;
        sat      <= '0;
        overflow <= 1'b0;
      end else begin
        for (int i = 0; i < N_CH; i++) begin
          if (counted_c[i]) begin
            cnt[i] <= cnt[i] + CNT_W'(1);
            if (cnt[i] == CNT_MAX - CNT_W'(1)) sat[i] <= 1'b1;
          end
        end
        if (sum_c > SUM_W'(TOT_MAX)) begin
          total    <= TOT_MAX;
          overflow <= 1'b1;
        end else begin
          total <= TOT_W'(sum_c);
        end
      end
    end
  end

  // Frame image of the live state, checksum in the last byte.
  always_comb begin
    for (int b = 0; b < BUF_N; b++) frame_c[b] = 8'h00;
    tot16_c    = 16'(total);
    frame_c[0] = FRAME_HDR;
    for (int i = 0; i < N_CH; i++) frame_c[i+1] = 8'(cnt[i]);
    frame_c[N_CH+1] = tot16_c[15:8];
    frame_c[N_CH+2] = tot16_c[7:0];
    csum_c = 8'h00;
    for (int unsigned b = 0; b < FLEN - 1; b++) csum_c = csum_c ^ frame_c[b];
    frame_c[FLEN-1] = csum_c;
  end

  // Sequencer registers, snapshot buffer and registered tx status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      tx_active <= 1'b0;
      tx_done   <= 1'b0;
      for (int b = 0; b < BUF_N; b++) frame_buf[b] <= 8'h00;
    end else begin
      state     <= state_nxt;
      idx       <= idx_nxt;
      tx_active <= tx_active_nxt;
      tx_done   <= (state_nxt == DONE);
      if (state == LOAD) begin
        for (int b = 0; b < BUF_N; b++) frame_buf[b] <= frame_c[b];
      end
    end
  end

  // Next-state logic: header goes out straight from LOAD, later bytes from GAP.
  always_comb begin
    state_nxt     = state;
    idx_nxt       = idx;
    uart_start_c  = 1'b0;
    uart_data_c   = FRAME_HDR;
    tx_active_nxt = tx_active;
    case (state)
      IDLE: begin
        tx_active_nxt = 1'b0;
        idx_nxt       = '0;
        if (pending) state_nxt = LOAD;
      end
      LOAD: begin
        uart_start_c  = ~uart_busy;
        tx_active_nxt = 1'b1;
        idx_nxt       = '0;
        state_nxt     = SEND;
      end
      SEND: begin
        if (uart_byte_done) begin
          state_nxt = GAP;
          if (idx == IDX_W'(FLEN - 1)) tx_active_nxt = 1'b0;
        end
      end
      GAP: begin
        idx_nxt = idx + IDX_W'(1);
        if (idx_nxt == IDX_W'(FLEN)) begin
          state_nxt = DONE;
        end else begin
          uart_start_c = ~uart_busy;
          uart_data_c  = frame_buf[idx_nxt];
          state_nxt    = SEND;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (uart_start_c),
    .data     (uart_data_c),
    .busy     (uart_busy),
    .byte_done(uart_byte_done),
    .serial   (tx_serial)
  );

endmodule
